// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the EX adder.
// Also raises load_use_hazard when an EX source waits on a load sitting in MEM.
module ex_operand_stage #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc,
  input  logic              id_use_pc,
  input  logic              id_use_imm,
  input  logic              id_sub,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              mem_is_load,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_ci,
  output logic [REG_AW-1:0] ex_rd,
  output logic              load_use_hazard
);

  logic              valid_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [31:0]       rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic              use_pc_q, use_imm_q, sub_q;

  logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
  logic [31:0] fwd_rs1, fwd_rs2, b_raw;

  // x0 is hard-wired zero, so a write targeting it must never be forwarded.
  assign mem_hit_rs1 = (rs1_q != '0) && mem_we && (mem_rd == rs1_q);
  assign mem_hit_rs2 = (rs2_q != '0) && mem_we && (mem_rd == rs2_q);
  assign wb_hit_rs1  = (rs1_q != '0) && wb_we  && (wb_rd  == rs1_q);
  assign wb_hit_rs2  = (rs2_q != '0) && wb_we  && (wb_rd  == rs2_q);

  // MEM holds the younger result, so it takes priority over WB.
  assign fwd_rs1 = mem_hit_rs1 ? mem_data : (wb_hit_rs1 ? wb_data : rs1_data_q);
  assign fwd_rs2 = mem_hit_rs2 ? mem_data : (wb_hit_rs2 ? wb_data : rs2_data_q);

  assign b_raw    = use_imm_q ? imm_q : fwd_rs2;
  assign add_a    = use_pc_q ? pc_q : fwd_rs1;
  assign add_b    = sub_q ? ~b_raw : b_raw;
  assign add_ci   = sub_q;
  assign ex_valid = valid_q;
  assign ex_rd    = rd_q;

  assign load_use_hazard = valid_q && mem_is_load &&
                           ((mem_hit_rs1 && !use_pc_q) || (mem_hit_rs2 && !use_imm_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      use_pc_q   <= 1'b0;
      use_imm_q  <= 1'b0;
      sub_q      <= 1'b0;
      rd_q       <= '0;
    end else if (flush || !stall) begin
      valid_q    <= flush ? 1'b0 : id_valid;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      pc_q       <= id_pc;
      use_pc_q   <= id_use_pc;
      use_imm_q  <= id_use_imm;
      sub_q      <= id_sub;
      rd_q       <= id_rd;
    end else if (!load_use_hazard) begin
      // Capture forwarded values while stalled so a WB result survives its retirement.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, add/sub, forwarding priority,
// load-use stall with operand refresh, and flush during stall.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_use_pc, id_use_imm, id_sub;
  logic        stall, flush;
  logic        mem_we, mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] add_a, add_b;
  logic        add_ci;
  logic [4:0]  ex_rd;
  logic        load_use_hazard;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_use_pc(id_use_pc),
    .id_use_imm(id_use_imm), .id_sub(id_sub), .id_rd(id_rd),
    .stall(stall), .flush(flush),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data), .mem_is_load(mem_is_load),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .ex_rd(ex_rd), .load_use_hazard(load_use_hazard)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    mem_we = 0; mem_rd = 0; mem_data = 0; mem_is_load = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic id_load(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic sub);
    id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_sub = sub; id_use_pc = 0; id_use_imm = 0; id_imm = 0; id_pc = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    clear_fwd();
    id_load(5'd1, 32'd5, 5'd2, 32'd3, 5'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_a", add_a, 32'd0);
    check("rst_b", add_b, 32'd0);
    check("rst_ci", {31'd0, add_ci}, 32'd0);
    check("rst_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_haz", {31'd0, load_use_hazard}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // ADD 5 + 3
    step();
    check("add_valid", {31'd0, ex_valid}, 32'd1);
    check("add_a", add_a, 32'd5);
    check("add_b", add_b, 32'd3);
    check("add_ci", {31'd0, add_ci}, 32'd0);
    check("add_rd", {27'd0, ex_rd}, 32'd4);

    // SUB 5 - 3 -> b inverted, carry-in 1
    id_sub = 1;
    step();
    check("sub_a", add_a, 32'd5);
    check("sub_b", add_b, 32'hFFFF_FFFC);
    check("sub_ci", {31'd0, add_ci}, 32'd1);

    // Asynchronous reset mid-cycle
    #3 rst_n = 0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_a", add_a, 32'd0);
    check("arst_b", add_b, 32'd0);
    check("arst_ci", {31'd0, add_ci}, 32'd0);
    #1 rst_n = 1;
    #2;
    check("arst_hold_valid", {31'd0, ex_valid}, 32'd0);
    step();
    check("arst_reload_valid", {31'd0, ex_valid}, 32'd1);
    check("arst_reload_b", add_b, 32'hFFFF_FFFC);

    // Forward priority: MEM over WB over register data
    id_load(5'd7, 32'h11, 5'd2, 32'd3, 5'd8, 1'b0);
    step();
    mem_we = 1; mem_rd = 7; mem_data = 32'hAAAA_0000;
    wb_we = 1; wb_rd = 7; wb_data = 32'h0000_1234;
    #1 check("fwd_mem_prio", add_a, 32'hAAAA_0000);
    mem_we = 0;
    #1 check("fwd_wb", add_a, 32'h0000_1234);
    wb_we = 0;
    #1 check("fwd_none", add_a, 32'h11);

    // x0 never forwarded
    clear_fwd();
    id_load(5'd0, 32'h22, 5'd0, 32'h33, 5'd8, 1'b0);
    step();
    mem_we = 1; mem_rd = 0; mem_data = 32'hAAAA_0000;
    wb_we = 1; wb_rd = 0; wb_data = 32'h0000_1234;
    #1 check("x0_a", add_a, 32'h22);
    check("x0_b", add_b, 32'h33);

    // Load-use on rs2, stall two cycles while the load drains through WB
    clear_fwd();
    id_load(5'd1, 32'd5, 5'd9, 32'h99, 5'd10, 1'b0);
    step();
    mem_we = 1; mem_rd = 9; mem_is_load = 1; mem_data = 32'h0000_0BAD;
    #1 check("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
    stall = 1;
    id_load(5'd3, 32'h44, 5'd3, 32'h55, 5'd11, 1'b0);
    step();
    clear_fwd();
    wb_we = 1; wb_rd = 9; wb_data = 32'hDEAD_BEEF;
    #1 check("lu_hazard_gone", {31'd0, load_use_hazard}, 32'd0);
    check("lu_wb_b", add_b, 32'hDEAD_BEEF);
    check("lu_hold_rd", {27'd0, ex_rd}, 32'd10);
    step();
    wb_we = 0;
    #1 check("lu_retired_b", add_b, 32'hDEAD_BEEF);
    check("lu_retired_a", add_a, 32'd5);
    check("lu_retired_valid", {31'd0, ex_valid}, 32'd1);
    stall = 0;
    step();
    check("lu_release_b", add_b, 32'h55);
    check("lu_release_rd", {27'd0, ex_rd}, 32'd11);

    // Flush beats stall
    stall = 1; flush = 1; id_valid = 1;
    step();
    check("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
    stall = 0; flush = 0;
    step();
    check("post_flush_valid", {31'd0, ex_valid}, 32'd1);

    // PC/imm operands, and no hazard on sources replaced by PC/imm
    id_load(5'd12, 32'h1, 5'd13, 32'h2, 5'd14, 1'b0);
    id_use_pc = 1; id_pc = 32'h0000_1000; id_use_imm = 1; id_imm = 32'hFFFF_FFF0;
    step();
    check("pc_a", add_a, 32'h0000_1000);
    check("imm_b", add_b, 32'hFFFF_FFF0);
    mem_we = 1; mem_is_load = 1; mem_rd = 12;
    #1 check("no_haz_pc", {31'd0, load_use_hazard}, 32'd0);
    mem_rd = 13;
    #1 check("no_haz_imm", {31'd0, load_use_hazard}, 32'd0);
    clear_fwd();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage of the 32-bit pipelined RISC-V CPU. It captures decoded operands from ID, resolves RAW hazards by forwarding from the MEM and WB stages, and drives the `a`, `b` and `ci` inputs of the EX-stage 32-bit adder. Subtraction is formed as a + ~b + 1. It also flags load-use hazards back to the hazard unit.

## Interface
- `REG_AW`, 5, register-address width
- `clk` in 1: clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `id_valid` in 1: ID holds a valid instruction
- `id_rs1`, `id_rs2` in REG_AW: source register addresses
- `id_rs1_data`, `id_rs2_data` in 32: register-file read data
- `id_imm` in 32: sign-extended immediate
- `id_pc` in 32: instruction PC
- `id_use_pc` in 1: operand A = PC instead of rs1
- `id_use_imm` in 1: operand B = imm instead of rs2
- `id_sub` in 1: subtract (invert B, carry-in 1)
- `id_rd` in REG_AW: destination register
- `stall` in 1: hold the EX register contents
- `flush` in 1: kill the instruction entering EX
- `mem_we` in 1, `mem_rd` in REG_AW, `mem_data` in 32, `mem_is_load` in 1: MEM-stage writeback info
- `wb_we` in 1, `wb_rd` in REG_AW, `wb_data` in 32: WB-stage writeback info
- `ex_valid` out 1: EX holds a valid instruction
- `add_a`, `add_b` out 32; `add_ci` out 1: adder operands
- `ex_rd` out REG_AW: EX destination register
- `load_use_hazard` out 1: EX source depends on the load currently in MEM

## Operation
- Registered state: `valid`, `rs1`, `rs2`, `rs1_data`, `rs2_data`, `imm`, `pc`, `use_pc`, `use_imm`, `sub`, `rd`.
- Forward match for source s: `s != 0` and the stage's `we` is set and the stage's `rd == s`.
- Forwarded value fwd(s):
  - `mem_data` if the MEM stage matches;
  - else `wb_data` if the WB stage matches;
  - else the held data.
  - MEM has priority over WB.
  - x0 is never forwarded.
- Adder outputs:
  - `add_a` = `use_pc` ? `pc` : fwd(rs1).
  - b_raw = `use_imm` ? `imm` : fwd(rs2).
  - `add_b` = `sub` ? ~b_raw : b_raw.
  - `add_ci` = `sub`.
  - All combinational from the registers and the forwarding inputs.
- `load_use_hazard` = `valid` & `mem_is_load` & (MEM matches rs1 with `!use_pc`, or MEM matches rs2 with `!use_imm`).
- Edge update, in priority order:
  - `flush`: `valid` is cleared; all other registers are don't-care but are loaded from ID. This applies even when `stall` is set.
  - `stall` (no flush): every field is held. Exception, the operand refresh:
    - If `load_use_hazard` = 0, `rs1_data` ← fwd(rs1) and `rs2_data` ← fwd(rs2).
    - Purpose: a value forwarded from WB survives that instruction's retirement while EX is stalled.
  - Otherwise: all fields are loaded from ID, and `valid` ← `id_valid`.
- When `valid` = 0, outputs keep following the registers. Consumers gate on `ex_valid`.

## Timing
- Reset (async, `rst_n` = 0): all registers cleared.
  - Outputs: `ex_valid` = 0, `add_a` = 0, `add_b` = 0, `add_ci` = 0, `ex_rd` = 0, `load_use_hazard` = 0.
- Latency: ID inputs present at edge N appear on `add_*` after edge N, one cycle later.
- Forwarding is same-cycle combinational: MEM/WB inputs during cycle N+1 affect `add_*` within cycle N+1.
- Reset asserted mid-stall or mid-hazard: state is cleared immediately. The first edge after deassertion is a normal load.
- Simultaneous `stall` and `flush`: flush wins and `ex_valid` is 0 next cycle.
- Simultaneous MEM and WB match on the same register: MEM data is used.
- The module does not generate `stall` itself. The hazard unit asserts `stall` in response to `load_use_hazard`.

## Test plan
- Reset: drive `rst_n` low mid-cycle with `id_valid` = 1 → outputs go to 0 immediately, without waiting for a clock edge; `ex_valid` stays 0 until the first edge after release.
- ADD: rs1_data = 0x0000_0005, rs2_data = 0x0000_0003, sub = 0 → next cycle `add_a` = 5, `add_b` = 3, `add_ci` = 0.
- SUB: same operands with sub = 1 → `add_b` = 0xFFFF_FFFC, `add_ci` = 1.
- Forward priority:
  - rs1 = 7; `mem_we` = 1, `mem_rd` = 7, `mem_data` = 0xAAAA_0000; `wb_we` = 1, `wb_rd` = 7, `wb_data` = 0x1234 → `add_a` = 0xAAAA_0000.
  - Repeat with rs1 = 0 and both stages at rd = 0 → `add_a` = register data, not forwarded.
- Load-use:
  - EX rs2 = 9; MEM holds a load with `mem_rd` = 9 → `load_use_hazard` = 1.
  - Hold `stall` = 1 for 2 cycles; the load reaches WB with `wb_data` = 0xDEAD_BEEF, then retires → `add_b` = 0xDEAD_BEEF in every cycle after WB, including after retirement.
- Flush during stall: `stall` = 1, `flush` = 1, `id_valid` = 1 → `ex_valid` = 0 next cycle.
